// File: rtl/srom_burst_reader_16_bit.sv
// Burst reader for a synchronous ROM: issues consecutive word reads starting at a
// base address and streams the words out through a 2-entry valid/ready buffer.
//
// state | meaning
// IDLE  | waiting for Start_In
// READ  | issuing addresses, one per cycle while credit allows
// DRAIN | all addresses issued, waiting for the last beat to transfer
// DONE  | one-cycle completion pulse; a new Start_In is accepted here
module srom_burst_reader_16_bit #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Start_In,
  input  logic [ADDR_WIDTH-1:0] Base_Address_In,
  input  logic [ADDR_WIDTH:0]   Length_In,
  output logic                  Busy_Out,
  output logic                  Done_Out,
  output logic                  SROM_Enable_Out,
  output logic                  SROM_Read_Enable_Out,
  output logic [ADDR_WIDTH-1:0] SROM_Address_Out,
  input  logic [DATA_WIDTH-1:0] SROM_Read_Data_In,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic                  Data_Valid_Out,
  input  logic                  Data_Ready_In,
  output logic                  Data_Last_Out
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] MAX_LEN = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                state_q, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   issue_left_q;
  logic [ADDR_WIDTH:0]   beats_left_q;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic [1:0]            fifo_cnt_q;

  logic [ADDR_WIDTH:0]   len_clamped;
  logic                  start_ok;
  logic                  pop;
  logic                  issue;
  logic                  credit;
  logic [2:0]            occupancy;

  assign len_clamped = (Length_In > MAX_LEN) ? MAX_LEN : Length_In;
  assign start_ok    = Start_In && ((state_q == IDLE) || (state_q == DONE));
  assign pop         = (fifo_cnt_q != 2'd0) && Data_Ready_In;
  // Credit counts words already buffered plus the one in flight, minus the one
  // leaving this cycle, so the buffer can never overflow.
  assign occupancy   = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
  assign credit      = occupancy < (3'd2 + {2'b00, pop});
  assign issue       = (state_q == READ) && (issue_left_q != '0) && credit;

  assign Busy_Out             = (state_q == READ) || (state_q == DRAIN);
  assign Done_Out             = (state_q == DONE);
  assign SROM_Enable_Out      = Busy_Out;
  // Read enable stays high during the capture cycle so the ROM keeps driving the
  // registered word; the stale-address read it also starts is simply discarded.
  assign SROM_Read_Enable_Out = issue || inflight_q;
  assign SROM_Address_Out     = addr_q;
  assign Data_Valid_Out       = (fifo_cnt_q != 2'd0);
  assign Data_Out             = Data_Valid_Out ? fifo_mem[0] : '0;
  assign Data_Last_Out        = Data_Valid_Out && (beats_left_q == ONE);

  // State register.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) state_q <= IDLE;
    else          state_q <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (Start_In) state_nxt = (len_clamped == '0) ? DONE : READ;
      end
      READ:  if (issue && (issue_left_q == ONE)) state_nxt = DRAIN;
      DRAIN: if (pop && (beats_left_q == ONE))   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address generator, issue/beat counters and in-flight flag.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      addr_q       <= '0;
      issue_left_q <= '0;
      beats_left_q <= '0;
      inflight_q   <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (start_ok) begin
        addr_q       <= Base_Address_In;
        issue_left_q <= len_clamped;
        beats_left_q <= len_clamped;
      end else begin
        if (issue) begin
          addr_q       <= addr_q + 1'b1;
          issue_left_q <= issue_left_q - ONE;
        end
        if (pop) beats_left_q <= beats_left_q - ONE;
      end
    end
  end

  // Two-entry output buffer; entry 0 is always the head.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      fifo_cnt_q  <= 2'd0;
    end else begin
      case ({inflight_q, pop})
        2'b10: begin
          fifo_mem[fifo_cnt_q[0]] <= SROM_Read_Data_In;
          fifo_cnt_q              <= fifo_cnt_q + 2'd1;
        end
        2'b01: begin
          fifo_mem[0] <= fifo_mem[1];
          fifo_cnt_q  <= fifo_cnt_q - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt_q == 2'd1) begin
            fifo_mem[0] <= SROM_Read_Data_In;
          end else begin
            fifo_mem[0] <= fifo_mem[1];
            fifo_mem[1] <= SROM_Read_Data_In;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_srom_burst_reader_16_bit.sv
// Bench for srom_burst_reader_16_bit: ROM model word[i] = 0xA000+i, scoreboard of
// expected beats consumed by a negedge monitor.
module tb_srom_burst_reader_16_bit;

  logic        Clk_In;
  logic        Reset_In;
  logic        Start_In;
  logic [3:0]  Base_Address_In;
  logic [4:0]  Length_In;
  logic        Busy_Out;
  logic        Done_Out;
  logic        SROM_Enable_Out;
  logic        SROM_Read_Enable_Out;
  logic [3:0]  SROM_Address_Out;
  logic [15:0] SROM_Read_Data_In;
  logic [15:0] Data_Out;
  logic        Data_Valid_Out;
  logic        Data_Ready_In;
  logic        Data_Last_Out;

  logic [15:0] rom_q;
  logic [16:0] sb[$];
  int          tests = 0;
  int          fails = 0;
  int          beats_seen = 0;
  bit          prev_stall = 0;
  logic [15:0] prev_data = '0;

  srom_burst_reader_16_bit #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) dut (
    .Clk_In(Clk_In), .Reset_In(Reset_In), .Start_In(Start_In),
    .Base_Address_In(Base_Address_In), .Length_In(Length_In),
    .Busy_Out(Busy_Out), .Done_Out(Done_Out),
    .SROM_Enable_Out(SROM_Enable_Out), .SROM_Read_Enable_Out(SROM_Read_Enable_Out),
    .SROM_Address_Out(SROM_Address_Out), .SROM_Read_Data_In(SROM_Read_Data_In),
    .Data_Out(Data_Out), .Data_Valid_Out(Data_Valid_Out),
    .Data_Ready_In(Data_Ready_In), .Data_Last_Out(Data_Last_Out)
  );

  initial Clk_In = 1'b0;
  always #5 Clk_In = ~Clk_In;

  // ROM model; 0xDEAD stands in for the undriven bus when read is disabled.
  always @(posedge Clk_In)
    if (SROM_Enable_Out && SROM_Read_Enable_Out) rom_q <= {12'hA00, SROM_Address_Out};
  assign SROM_Read_Data_In = SROM_Read_Enable_Out ? rom_q : 16'hDEAD;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk_In);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] base, input logic [4:0] len);
    int n;
    logic [3:0] a;
    n = (len > 5'd16) ? 16 : int'(len);
    for (int i = 0; i < n; i++) begin
      a = base + 4'(i);
      sb.push_back({(i == n - 1), 12'hA00, a});
    end
  endtask

  task automatic start_burst(input logic [3:0] base, input logic [4:0] len, input bit accept);
    Start_In = 1'b1;
    Base_Address_In = base;
    Length_In = len;
    if (accept) push_exp(base, len);
    tick();
    Start_In = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk_In);
      if (Done_Out) begin
        seen = 1;
        break;
      end
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_busy_low_at_done"}, 32'(Busy_Out), 32'd0);
  endtask

  task automatic after_done(input string name);
    @(negedge Clk_In);
    check({name, "_done_one_cycle"}, 32'(Done_Out), 32'd0);
    check({name, "_all_beats"}, 32'(sb.size()), 32'd0);
    tick();
  endtask

  // Monitor: consumes the scoreboard on every transfer and checks stall stability.
  always @(negedge Clk_In) begin
    logic [16:0] exp;
    if (Reset_In) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_data", 32'(Data_Out), 32'(prev_data));
        check("stall_hold_valid", 32'(Data_Valid_Out), 32'd1);
      end
      if (Data_Valid_Out && Data_Ready_In) begin
        beats_seen++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got %0h expected no beat at %0t", Data_Out, $time);
        end else begin
          exp = sb.pop_front();
          check("beat_data", 32'(Data_Out), 32'(exp[15:0]));
          check("beat_last", 32'(Data_Last_Out), 32'(exp[16]));
        end
      end
      prev_stall = Data_Valid_Out && !Data_Ready_In;
      prev_data  = Data_Out;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  b0;
    bit  hit;
    Reset_In = 1'b1;
    Start_In = 1'b0;
    Base_Address_In = '0;
    Length_In = '0;
    Data_Ready_In = 1'b1;

    @(negedge Clk_In);
    check("rst_busy", 32'(Busy_Out), 32'd0);
    check("rst_done", 32'(Done_Out), 32'd0);
    check("rst_valid", 32'(Data_Valid_Out), 32'd0);
    check("rst_data", 32'(Data_Out), 32'd0);
    check("rst_en", 32'(SROM_Enable_Out), 32'd0);
    check("rst_rden", 32'(SROM_Read_Enable_Out), 32'd0);
    tick();
    Reset_In = 1'b0;
    tick();
    tick();

    // Full 16-word burst from 0 with exact latency.
    start_burst(4'h0, 5'd16, 1);
    @(negedge Clk_In);
    check("t1_latency_c1", 32'(Data_Valid_Out), 32'd0);
    @(negedge Clk_In);
    check("t1_latency_c2", 32'(Data_Valid_Out), 32'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk_In);
      check("t1_stream_valid", 32'(Data_Valid_Out), 32'd1);
    end
    check("t1_busy_last_beat", 32'(Busy_Out), 32'd1);
    wait_done(5, "t1");
    after_done("t1");

    // Address wrap.
    start_burst(4'hE, 5'd4, 1);
    wait_done(20, "t2");
    after_done("t2");

    // Over-length request clamps to 16.
    start_burst(4'h0, 5'd20, 1);
    wait_done(40, "clamp");
    after_done("clamp");

    // Back-pressure: ready toggling with a 6-cycle low hold.
    start_burst(4'h3, 5'd5, 1);
    hit = 0;
    for (int k = 0; k < 80; k++) begin
      Data_Ready_In = (k >= 4 && k < 10) ? 1'b0 : (k % 2 == 0);
      @(negedge Clk_In);
      if (Done_Out) begin
        hit = 1;
        break;
      end
      tick();
    end
    check("t3_done_seen", 32'(hit), 32'd1);
    Data_Ready_In = 1'b1;
    after_done("t3");

    // Zero length.
    start_burst(4'h7, 5'd0, 1);
    @(negedge Clk_In);
    check("t4_done", 32'(Done_Out), 32'd1);
    check("t4_rden", 32'(SROM_Read_Enable_Out), 32'd0);
    check("t4_valid", 32'(Data_Valid_Out), 32'd0);
    check("t4_busy", 32'(Busy_Out), 32'd0);
    @(negedge Clk_In);
    check("t4_done_one_cycle", 32'(Done_Out), 32'd0);
    check("t4_rden_after", 32'(SROM_Read_Enable_Out), 32'd0);
    tick();

    // Reset mid-burst after the 3rd beat.
    b0 = beats_seen;
    start_burst(4'h0, 5'd8, 1);
    hit = 0;
    for (int k = 0; k < 40; k++) begin
      if (beats_seen >= b0 + 3) begin
        hit = 1;
        break;
      end
      tick();
    end
    check("t5_three_beats", 32'(hit), 32'd1);
    Reset_In = 1'b1;
    #1;
    check("t5_busy", 32'(Busy_Out), 32'd0);
    check("t5_valid", 32'(Data_Valid_Out), 32'd0);
    check("t5_data", 32'(Data_Out), 32'd0);
    check("t5_last", 32'(Data_Last_Out), 32'd0);
    check("t5_rden", 32'(SROM_Read_Enable_Out), 32'd0);
    check("t5_en", 32'(SROM_Enable_Out), 32'd0);
    check("t5_addr", 32'(SROM_Address_Out), 32'd0);
    sb.delete();
    tick();
    Reset_In = 1'b0;
    @(negedge Clk_In);
    check("t5_idle_busy", 32'(Busy_Out), 32'd0);
    check("t5_idle_valid", 32'(Data_Valid_Out), 32'd0);
    tick();
    start_burst(4'h0, 5'd2, 1);
    wait_done(10, "t5b");
    after_done("t5b");

    // Start ignored while busy, accepted during Done.
    start_burst(4'h8, 5'd3, 1);
    tick();
    start_burst(4'h0, 5'd5, 0);
    wait_done(20, "t6a");
    Start_In = 1'b1;
    Base_Address_In = 4'h5;
    Length_In = 5'd2;
    push_exp(4'h5, 5'd2);
    tick();
    Start_In = 1'b0;
    @(negedge Clk_In);
    check("t6_restart_busy", 32'(Busy_Out), 32'd1);
    wait_done(10, "t6b");
    after_done("t6b");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
